// File: rtl/tile_operand_streamer.sv
// tile_operand_streamer: tile-ordered A/B operand sequencer over two 1-cycle RAMs.
// Optional STREAMER_STALL_CNT_EN adds stall_cnt_out (stalled-beat cycle counter).
module tile_operand_streamer #(
   parameter int DATA_WIDTH  = 64,
   parameter int A_NUM_WIDTH = 3,
   parameter int B_NUM_WIDTH = 3,
   parameter int N_MAX_WIDTH = 32,
   parameter int ADDR_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_in,
   input  logic [N_MAX_WIDTH-1:0] N_in,
   output logic                   A_rd_en_out,
   output logic [ADDR_WIDTH-1:0]  A_addr_out,
   input  logic [DATA_WIDTH-1:0]  A_rd_data_in,
   output logic                   B_rd_en_out,
   output logic [ADDR_WIDTH-1:0]  B_addr_out,
   input  logic [DATA_WIDTH-1:0]  B_rd_data_in,
   output logic [DATA_WIDTH-1:0]  A_out,
   output logic [DATA_WIDTH-1:0]  B_out,
   output logic                   A_valid_out,
   output logic                   B_valid_out,
   input  logic                   out_ready_in,
   output logic                   busy_out,
   output logic                   done_out,
`ifdef STREAMER_STALL_CNT_EN
   output logic [31:0]            stall_cnt_out,
`endif
   output logic                   err_out
);

   localparam int SI   = 1 << A_NUM_WIDTH;
   localparam int SJ   = 1 << B_NUM_WIDTH;
   localparam int SMAX = (SI > SJ) ? SI : SJ;
   localparam int IW   = (SMAX > 1) ? $clog2(SMAX) : 1;

   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
   localparam logic [2*N_MAX_WIDTH-1:0] NSQ_LIM =
      (2*N_MAX_WIDTH)'(1) << ADDR_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic                  av;
      logic                  bv;
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
   } beat_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] nsz_q, nsz_d;
   logic [ADDR_WIDTH-1:0] n_q, n_d, j_q, j_d, i_q, i_d;
   logic [IW-1:0]         ii_q, ii_d;
   logic                  err_q, err_d;
   logic                  inflight_q, inflight_d;
   logic                  inf_av_q, inf_av_d;
   logic                  inf_bv_q, inf_bv_d;
   beat_t [1:0]           fifo_q, fifo_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            cnt_q, cnt_d;

   logic [2*N_MAX_WIDTH-1:0] n_wide, nsq;
   logic                  n_ok, start_ok;
   logic                  pop, issue, a_lane, b_lane, out_vld;
   logic [2:0]            occ;
   logic [ADDR_WIDTH-1:0] row_a, col_b, j_last, i_last;
   beat_t                 head;

   always_comb begin
      n_wide   = (2*N_MAX_WIDTH)'(N_in);
      nsq      = n_wide * n_wide;
      n_ok     = (N_in != '0)
              && ((N_in & N_MAX_WIDTH'(SI - 1)) == '0)
              && ((N_in & N_MAX_WIDTH'(SJ - 1)) == '0)
              && (nsq <= NSQ_LIM);
      start_ok = (state_q == S_IDLE) && start_in && n_ok;
   end

   // Occupancy counts reads still in the RAM pipe so the 2-deep FIFO never overflows.
   assign head    = fifo_q[rd_ptr_q];
   assign out_vld = (cnt_q != 2'd0);
   assign pop     = out_vld & out_ready_in;
   assign occ     = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
   assign issue   = (state_q == S_RUN) && (occ < 3'd2);
   assign a_lane  = (int'(ii_q) < SI);
   assign b_lane  = (int'(ii_q) < SJ);

   assign i_last = (nsz_q >> A_NUM_WIDTH) - ONE;
   assign j_last = (nsz_q >> B_NUM_WIDTH) - ONE;
   assign row_a  = (i_q << A_NUM_WIDTH) + ADDR_WIDTH'(ii_q);
   assign col_b  = (j_q << B_NUM_WIDTH) + ADDR_WIDTH'(ii_q);

   assign A_rd_en_out = issue & a_lane;
   assign B_rd_en_out = issue & b_lane;
   assign A_addr_out  = A_rd_en_out ? (row_a * nsz_q + n_q) : '0;
   assign B_addr_out  = B_rd_en_out ? (n_q * nsz_q + col_b) : '0;

   assign A_valid_out = out_vld & head.av;
   assign B_valid_out = out_vld & head.bv;
   assign A_out       = A_valid_out ? head.a : '0;
   assign B_out       = B_valid_out ? head.b : '0;
   assign busy_out    = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done_out    = (state_q == S_DONE);
   assign err_out     = err_q;

   always_comb begin
      state_d    = state_q;
      nsz_d      = nsz_q;
      err_d      = err_q;
      n_d        = n_q;
      j_d        = j_q;
      i_d        = i_q;
      ii_d       = ii_q;
      inflight_d = issue;
      inf_av_d   = issue & a_lane;
      inf_bv_d   = issue & b_lane;
      unique case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d = S_RUN;
               nsz_d   = ADDR_WIDTH'(N_in);
               err_d   = 1'b0;
               n_d     = '0;
               j_d     = '0;
               i_d     = '0;
               ii_d    = '0;
            end else if (start_in) begin
               err_d = 1'b1;
            end
         end
         S_RUN: begin
            if (issue) begin
               if (ii_q != IW'(SMAX - 1)) begin
                  ii_d = ii_q + IW'(1);
               end else begin
                  ii_d = '0;
                  if (n_q != nsz_q - ONE) begin
                     n_d = n_q + ONE;
                  end else begin
                     n_d = '0;
                     if (j_q != j_last) begin
                        j_d = j_q + ONE;
                     end else begin
                        j_d = '0;
                        if (i_q != i_last) begin
                           i_d = i_q + ONE;
                        end else begin
                           i_d     = '0;
                           state_d = S_DRAIN;
                        end
                     end
                  end
               end
            end
         end
         // Finish as the last beat leaves so done lands the cycle after it.
         S_DRAIN: begin
            if (cnt_d == 2'd0 && !inflight_q) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q ^ inflight_q;
      rd_ptr_d = rd_ptr_q ^ pop;
      cnt_d    = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
      if (inflight_q) begin
         fifo_d[wr_ptr_q].av = inf_av_q;
         fifo_d[wr_ptr_q].bv = inf_bv_q;
         fifo_d[wr_ptr_q].a  = inf_av_q ? A_rd_data_in : '0;
         fifo_d[wr_ptr_q].b  = inf_bv_q ? B_rd_data_in : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         nsz_q      <= '0;
         err_q      <= 1'b0;
         n_q        <= '0;
         j_q        <= '0;
         i_q        <= '0;
         ii_q       <= '0;
         inflight_q <= 1'b0;
         inf_av_q   <= 1'b0;
         inf_bv_q   <= 1'b0;
         fifo_q     <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         cnt_q      <= 2'd0;
      end else begin
         state_q    <= state_d;
         nsz_q      <= nsz_d;
         err_q      <= err_d;
         n_q        <= n_d;
         j_q        <= j_d;
         i_q        <= i_d;
         ii_q       <= ii_d;
         inflight_q <= inflight_d;
         inf_av_q   <= inf_av_d;
         inf_bv_q   <= inf_bv_d;
         fifo_q     <= fifo_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

`ifdef STREAMER_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (start_ok) begin
         stall_d = '0;
      end else if (busy_out && out_vld && !out_ready_in && stall_q != '1) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end

   assign stall_cnt_out = stall_q;
`endif

endmodule

// File: tb/tb_tile_operand_streamer.sv
// Scoreboard bench for tile_operand_streamer with Si=4, Sj=8 (unequal tiles).
// Reference beats come from plain tile loops over the RAM contents.
module tb_tile_operand_streamer;

   localparam int DW = 64;
   localparam int AN = 2;
   localparam int BN = 3;
   localparam int NW = 32;
   localparam int AW = 16;
   localparam int SI = 4;
   localparam int SJ = 8;
   localparam int SM = 8;

   typedef struct packed {
      logic          av;
      logic          bv;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_in;
   logic [NW-1:0] N_in;
   logic          A_rd_en_out, B_rd_en_out;
   logic [AW-1:0] A_addr_out, B_addr_out;
   logic [DW-1:0] A_rd_data_in, B_rd_data_in;
   logic [DW-1:0] A_out, B_out;
   logic          A_valid_out, B_valid_out;
   logic          out_ready_in;
   logic          busy_out, done_out, err_out;
`ifdef STREAMER_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   logic [DW-1:0] mem_a [0:(1<<AW)-1];
   logic [DW-1:0] mem_b [0:(1<<AW)-1];

   beat_t exp_q[$];
   beat_t e;
   int    checks = 0;
   int    failures = 0;
   int    beats_seen = 0;
   int    stall_seen = 0;
   int    rmode = 0;
   bit    pend_done = 0;

   tile_operand_streamer #(
      .DATA_WIDTH (DW),
      .A_NUM_WIDTH(AN),
      .B_NUM_WIDTH(BN),
      .N_MAX_WIDTH(NW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start_in     (start_in),
      .N_in         (N_in),
      .A_rd_en_out  (A_rd_en_out),
      .A_addr_out   (A_addr_out),
      .A_rd_data_in (A_rd_data_in),
      .B_rd_en_out  (B_rd_en_out),
      .B_addr_out   (B_addr_out),
      .B_rd_data_in (B_rd_data_in),
      .A_out        (A_out),
      .B_out        (B_out),
      .A_valid_out  (A_valid_out),
      .B_valid_out  (B_valid_out),
      .out_ready_in (out_ready_in),
      .busy_out     (busy_out),
      .done_out     (done_out),
`ifdef STREAMER_STALL_CNT_EN
      .stall_cnt_out(stall_cnt),
`endif
      .err_out      (err_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (A_rd_en_out) A_rd_data_in <= mem_a[A_addr_out];
      if (B_rd_en_out) B_rd_data_in <= mem_b[B_addr_out];
   end

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   // Monitor: any presented beat must match the queue head, stalled or not.
   always @(negedge clk) begin
      if (pend_done) begin
         chk("done_after_last_beat", 64'(done_out), 64'd1);
         pend_done = 0;
      end
      if (A_valid_out | B_valid_out) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat got A=%0h B=%0h exp=none",
                     A_out, B_out);
         end else begin
            e = exp_q[0];
            chk("beat_flags", 64'({A_valid_out, B_valid_out}),
                64'({e.av, e.bv}));
            chk("beat_a", A_out, e.a);
            chk("beat_b", B_out, e.b);
            if (out_ready_in) begin
               e = exp_q.pop_front();
               beats_seen++;
               if (exp_q.size() == 0) pend_done = 1;
            end else begin
               stall_seen++;
            end
         end
      end
   end

   initial begin
      out_ready_in = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0:       out_ready_in = 1'b1;
            1:       out_ready_in = ~out_ready_in;
            2:       out_ready_in = 1'($urandom_range(0, 1));
            default: out_ready_in = (stall_seen >= 7);
         endcase
      end
   end

   task automatic build_model(input int n);
      beat_t b;
      for (int k = 0; k < n * n; k++) begin
         mem_a[k] = {$urandom, $urandom};
         mem_b[k] = {$urandom, $urandom};
      end
      for (int i = 0; i < n / SI; i++)
         for (int j = 0; j < n / SJ; j++)
            for (int nn = 0; nn < n; nn++)
               for (int ii = 0; ii < SM; ii++) begin
                  b.av = (ii < SI);
                  b.bv = (ii < SJ);
                  b.a  = b.av ? mem_a[(i * SI + ii) * n + nn] : '0;
                  b.b  = b.bv ? mem_b[nn * n + j * SJ + ii] : '0;
                  exp_q.push_back(b);
               end
   endtask

   task automatic do_start(input int n);
      @(posedge clk);
      #1;
      start_in = 1'b1;
      N_in     = NW'(n);
      @(posedge clk);
      #1;
      start_in = 1'b0;
   endtask

   task automatic run(input int n, input int mode);
      int         cyc;
      int         base;
      logic [2:0] lat;
      build_model(n);
      rmode      = mode;
      stall_seen = 0;
      base       = beats_seen;
      lat        = '0;
      do_start(n);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         lat = {lat[1:0], A_valid_out | B_valid_out};
      end
      chk("first_valid_cycle3", 64'(lat), 64'b001);
      chk("busy_in_run", 64'(busy_out), 64'd1);
      chk("err_clear_on_start", 64'(err_out), 64'd0);
      @(posedge clk);
      #1;
      start_in = 1'b1;
      N_in     = NW'($urandom_range(1, 64));
      @(posedge clk);
      #1;
      start_in = 1'b0;
      cyc = 0;
      while (!done_out && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      if (!done_out) begin
         checks++;
         failures++;
         $display("FAIL done_timeout got=%0d beats exp=%0d",
                  beats_seen - base, (n / SI) * (n / SJ) * n * SM);
         rst = 1'b1;
         #1;
         exp_q.delete();
         pend_done = 0;
         @(posedge clk);
         #1;
         rst = 1'b0;
      end else begin
         chk("beat_count", 64'(beats_seen - base),
             64'((n / SI) * (n / SJ) * n * SM));
         chk("queue_drained", 64'(exp_q.size()), 64'd0);
         @(negedge clk);
         chk("done_one_cycle", 64'(done_out), 64'd0);
         chk("idle_after_done", 64'(busy_out), 64'd0);
      end
      rmode = 0;
   endtask

   task automatic bad_start(input int n);
      logic seen;
      do_start(n);
      @(negedge clk);
      chk("err_set", 64'(err_out), 64'd1);
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         seen = seen | busy_out | done_out;
         @(negedge clk);
      end
      chk("err_no_busy_no_done", 64'(seen), 64'd0);
   endtask

   initial begin
      int cyc;
      int base;
      rst      = 1'b1;
      start_in = 1'b0;
      N_in     = '0;
      #1;
      chk("rst_valids", 64'({A_valid_out, B_valid_out}), 64'd0);
      chk("rst_status", 64'({busy_out, done_out, err_out}), 64'd0);
      chk("rst_rd_en", 64'({A_rd_en_out, B_rd_en_out}), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      bad_start(12);
      bad_start(0);
      bad_start(264);

      run(16, 0);
      run(16, 1);
      run(8, 2);
      run(16, 2);

      build_model(16);
      rmode = 2;
      base  = beats_seen;
      do_start(16);
      cyc = 0;
      while (beats_seen < base + 100 && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_valids", 64'({A_valid_out, B_valid_out}), 64'd0);
      chk("midrst_outs", A_out | B_out, 64'd0);
      chk("midrst_busy_done", 64'({busy_out, done_out}), 64'd0);
      chk("midrst_rd_en", 64'({A_rd_en_out, B_rd_en_out}), 64'd0);
      exp_q.delete();
      pend_done = 0;
      rmode     = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      run(16, 0);

`ifdef STREAMER_STALL_CNT_EN
      run(8, 3);
      chk("stall_cnt", 64'(stall_cnt), 64'd7);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
